// File: rtl/cache_line_xfer_engine.sv
// Moves one cache line over AXI4: optional victim write-back burst, then optional refill burst.
// Latency: bus VALIDs appear the cycle after start; complete pulses one cycle after the final B or R handshake.
// Backpressure: every VALID and its payload are held until READY; BREADY/RREADY are high whenever a response is awaited.
module cache_line_xfer_engine #(
    parameter int                    LINE_SIZE              = 512,
    parameter int                    DATA_WIDTH             = 128,
    parameter int                    ADDR_WIDTH             = 27,
    parameter int                    ID_WIDTH               = 1,
    parameter logic [ADDR_WIDTH-1:0] TARGET_SLAVE_BASE_ADDR = '0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [LINE_SIZE-1:0]    din,
    output logic [LINE_SIZE-1:0]    dout,
    output logic                    busy,
    output logic                    complete,
    output logic                    error,
    // write address channel
    output logic [ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]              M_AXI_AWLEN,
    output logic [2:0]              M_AXI_AWSIZE,
    output logic [1:0]              M_AXI_AWBURST,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    // write data channel
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WLAST,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    // write response channel
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    // read address channel
    output logic [ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]              M_AXI_ARLEN,
    output logic [2:0]              M_AXI_ARSIZE,
    output logic [1:0]              M_AXI_ARBURST,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    // read data channel
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RLAST,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    localparam int                    BURST_LEN = LINE_SIZE / DATA_WIDTH;
    localparam int                    CNT_W     = $clog2(BURST_LEN) + 1;
    localparam int                    LINE_OFF  = $clog2(LINE_SIZE / 8);
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [7:0]            AXLEN     = 8'(BURST_LEN - 1);
    localparam logic [2:0]            AXSIZE    = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [1:0]            AXBURST   = 2'b01;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~((ADDR_WIDTH'(1) << LINE_OFF) - ADDR_WIDTH'(1));

    localparam logic [1:0] MODE_REFILL = 2'b00;
    localparam logic [1:0] MODE_WB_RF  = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_WRESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [1:0]              r_mode;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [LINE_SIZE-1:0]    r_din;
    logic [LINE_SIZE-1:0]    r_dout;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic [CNT_W-1:0]        r_wcnt;
    logic [CNT_W-1:0]        r_rcnt;
    logic                    r_error;

    logic                    w_start_ok;
    logic                    w_awvalid;
    logic                    w_wvalid;
    logic                    w_bready;
    logic                    w_arvalid;
    logic                    w_rready;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_w_last;
    logic                    w_w_last_hs;
    logic                    w_b_hs;
    logic                    w_ar_hs;
    logic                    w_r_hs;
    logic                    w_r_final;
    logic                    w_rlast_bad;
    logic [DATA_WIDTH-1:0]   w_wdata;

    // A request is only taken from IDLE and never with the reserved mode.
    assign w_start_ok  = start && (mode != MODE_RSVD) && (r_state == S_IDLE);

    assign w_aw_hs     = w_awvalid && M_AXI_AWREADY;
    assign w_w_hs      = w_wvalid && M_AXI_WREADY;
    assign w_w_last    = (r_wcnt == LAST_BEAT);
    assign w_w_last_hs = w_w_hs && w_w_last;
    assign w_b_hs      = w_bready && M_AXI_BVALID;
    assign w_ar_hs     = w_arvalid && M_AXI_ARREADY;
    assign w_r_hs      = w_rready && M_AXI_RVALID;
    assign w_r_final   = w_r_hs && (r_rcnt == LAST_BEAT);
    // RLAST must appear exactly on the final beat; early or missing both flag an error.
    assign w_rlast_bad = (r_rcnt == LAST_BEAT) ? !M_AXI_RLAST : M_AXI_RLAST;

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state channel controls.
    always_comb begin
        w_next    = r_state;
        w_awvalid = 1'b0;
        w_wvalid  = 1'b0;
        w_bready  = 1'b0;
        w_arvalid = 1'b0;
        w_rready  = 1'b0;
        busy      = 1'b1;
        complete  = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_start_ok) begin
                    w_next = (mode == MODE_REFILL) ? S_RD_ADDR : S_WB;
                end
            end
            S_WB: begin
                w_awvalid = !r_aw_done;
                w_wvalid  = !r_w_done;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_last_hs)) begin
                    w_next = S_WRESP;
                end
            end
            S_WRESP: begin
                w_bready = 1'b1;
                if (w_b_hs) begin
                    w_next = (r_mode == MODE_WB_RF) ? S_RD_ADDR : S_DONE;
                end
            end
            S_RD_ADDR: begin
                w_arvalid = 1'b1;
                if (w_ar_hs) begin
                    w_next = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                w_rready = 1'b1;
                if (w_r_final) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                complete = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Snapshot the request so later input changes cannot disturb an in-flight transfer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_mode    <= '0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_din     <= '0;
        end else if (w_start_ok) begin
            r_mode    <= mode;
            r_rd_addr <= rd_addr;
            r_wr_addr <= wr_addr;
            r_din     <= din;
        end
    end

    // Write-back progress: AW and W retire independently, beat counter stops on the last beat.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_wcnt    <= '0;
        end else if (w_start_ok) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_wcnt    <= '0;
        end else begin
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                if (w_w_last) begin
                    r_w_done <= 1'b1;
                end else begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
            end
        end
    end

    // Refill: each accepted R beat lands in its slot of the line buffer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rcnt <= '0;
            r_dout <= '0;
        end else if (w_start_ok) begin
            r_rcnt <= '0;
        end else if (w_r_hs) begin
            r_rcnt <= r_rcnt + 1'b1;
            for (int k = 0; k < BURST_LEN; k++) begin
                if (r_rcnt == CNT_W'(k)) begin
                    r_dout[k*DATA_WIDTH +: DATA_WIDTH] <= M_AXI_RDATA;
                end
            end
        end
    end

    // Sticky error: cleared by an accepted request, set by bad responses or RLAST misplacement.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_error <= 1'b0;
        end else if (w_start_ok) begin
            r_error <= 1'b0;
        end else begin
            if (w_b_hs && (M_AXI_BRESP != 2'b00)) begin
                r_error <= 1'b1;
            end
            if (w_r_hs && ((M_AXI_RRESP != 2'b00) || w_rlast_bad)) begin
                r_error <= 1'b1;
            end
        end
    end

    // Write beat selection from the captured victim line.
    always_comb begin
        w_wdata = '0;
        for (int k = 0; k < BURST_LEN; k++) begin
            if (r_wcnt == CNT_W'(k)) begin
                w_wdata = r_din[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign dout          = r_dout;
    assign error         = r_error;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = TARGET_SLAVE_BASE_ADDR + (r_wr_addr & LINE_MASK);
    assign M_AXI_AWLEN   = AXLEN;
    assign M_AXI_AWSIZE  = AXSIZE;
    assign M_AXI_AWBURST = AXBURST;
    assign M_AXI_AWVALID = w_awvalid;

    assign M_AXI_WDATA   = w_wdata;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = w_wvalid && w_w_last;
    assign M_AXI_WVALID  = w_wvalid;

    assign M_AXI_BREADY  = w_bready;

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = TARGET_SLAVE_BASE_ADDR + (r_rd_addr & LINE_MASK);
    assign M_AXI_ARLEN   = AXLEN;
    assign M_AXI_ARSIZE  = AXSIZE;
    assign M_AXI_ARBURST = AXBURST;
    assign M_AXI_ARVALID = w_arvalid;

    assign M_AXI_RREADY  = w_rready;

endmodule

// File: doc/cache_line_xfer_engine.md
CACHE_LINE_XFER_ENGINE -- requirements
Module: cache_line_xfer_engine

Interface
REQ-001 SHALL have parameter LINE_SIZE, default 512, cache line width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 128, AXI beat width; BURST_LEN = LINE_SIZE/DATA_WIDTH, legal range 1..256.
REQ-003 SHALL have parameter ADDR_WIDTH, default 27, AXI address width.
REQ-004 SHALL have parameter ID_WIDTH, default 1, AXI ID width; AWID/ARID tied to 0.
REQ-005 SHALL have parameter TARGET_SLAVE_BASE_ADDR, default 0, added to every issued address.
REQ-006 SHALL have port clk, in, 1, the single clock; all logic on rising edge.
REQ-007 SHALL have port rstn, in, 1, reset, synchronous, active-low.
REQ-008 SHALL have ports start in 1 (one-cycle request pulse) and mode in 2 (00 refill, 01 write-back, 10 write-back then refill, 11 reserved).
REQ-009 SHALL have ports rd_addr in ADDR_WIDTH (refill line address) and wr_addr in ADDR_WIDTH (victim line address).
REQ-010 SHALL have ports din in LINE_SIZE (victim line) and dout out LINE_SIZE (refilled line).
REQ-011 SHALL have ports busy out 1, complete out 1 (one-cycle done pulse) and error out 1 (valid with complete).
REQ-012 SHALL have AXI4 master ports M_AXI_AW{ID,ADDR,LEN,SIZE,BURST,VALID} out / AWREADY in; M_AXI_W{DATA,STRB,LAST,VALID} out / WREADY in; M_AXI_B{RESP,VALID} in / BREADY out; M_AXI_AR{ID,ADDR,LEN,SIZE,BURST,VALID} out / ARREADY in; M_AXI_R{DATA,RESP,LAST,VALID} in / RREADY out.

Function
REQ-013 SHALL drive AxLEN = BURST_LEN-1, AxSIZE = log2(DATA_WIDTH/8), AxBURST = INCR, WSTRB all ones.
REQ-014 SHALL issue AxADDR = TARGET_SLAVE_BASE_ADDR + address with low log2(LINE_SIZE/8) bits forced to 0.
REQ-015 SHALL implement FSM IDLE -> WB (AW+W) -> WRESP -> [RD_ADDR -> RD_DATA] -> DONE -> IDLE; mode 00 enters RD_ADDR directly, mode 01 goes WRESP -> DONE.
REQ-016 SHALL capture mode, both addresses and din on the start cycle; later input changes have no effect.
REQ-017 SHALL assert AWVALID/WVALID (or ARVALID) the cycle after start; busy high from that cycle until complete inclusive.
REQ-018 SHALL ignore start while busy and ignore start with mode 11 (no bus activity, no complete).
REQ-019 SHALL hold each VALID and its payload stable until the matching READY; AW and W independent (W may complete before AW).
REQ-020 SHALL send beat k = din[k*DATA_WIDTH +: DATA_WIDTH], k = 0..BURST_LEN-1, WLAST only on beat BURST_LEN-1, zero-bubble when WREADY stays high.
REQ-021 SHALL enter WRESP only after AW accepted and last W beat accepted; BREADY high in WRESP, one B handshake consumed.
REQ-022 SHALL hold RREADY high in RD_DATA; beat k written to dout[k*DATA_WIDTH +: DATA_WIDTH]; dout unchanged outside RD_DATA.
REQ-023 SHALL leave RD_DATA on the BURST_LEN-th beat; RLAST missing on that beat or present earlier SHALL set error (burst still counted to BURST_LEN).
REQ-024 SHALL set sticky error on any BRESP or RRESP != OKAY; mode 10 SHALL still perform refill after failed write-back.
REQ-025 SHALL pulse complete one cycle in DONE with error; error cleared on next accepted start.
REQ-026 SHALL size beat counters ceil(log2(BURST_LEN))+1 bits, no wrap within a burst.

Reset
REQ-027 SHALL on rstn=0 at a clock edge force IDLE, all VALID/READY/WLAST, busy, complete, error and counters to 0, dout to 0.
REQ-028 SHALL abort any in-flight transfer on reset with no complete pulse; start coincident with rstn=0 ignored.

Verification
REQ-029 SHALL cover: mode 00, BURST_LEN 4, slave ready always -> ARVALID cycle 1, 4 beats 0xA..0xD land in dout[127:0]..[511:384], complete 1 cycle, error 0.
REQ-030 SHALL cover: mode 01, din beats 1,2,3,4, WREADY toggling 1/0 -> WDATA order 1,2,3,4, WLAST only with 4, BRESP OKAY -> complete, dout unchanged.
REQ-031 SHALL cover: mode 10, BRESP=SLVERR -> refill still executes, complete with error=1; next start clears error.
REQ-032 SHALL cover: RLAST on beat 3 of 4 -> all 4 beats accepted, error=1 at complete.
REQ-033 SHALL cover: start while busy and mode 11 start -> no new AR/AW, exactly one complete per accepted request.
REQ-034 SHALL cover: rstn low mid-W burst -> next cycle all VALIDs 0, busy 0, no complete; fresh mode 00 request then succeeds.
